latency_checker: RTL and testbench
==================================

LATENCY_CHECKER -- requirements
Module: latency_checker

Interface
REQ-001 Parameter DELAY, default 3, cycles from antecedent sample to consequent sample; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, width of pass/fail counters.
REQ-003 Parameter TS_W, default 16, width of the free-running cycle timestamp.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 en  in  1  1 = new antecedents accepted; 0 = new antecedents ignored.
REQ-007 clr  in  1  synchronous clear of counters, sticky flag and first-fail capture.
REQ-008 a  in  1  antecedent, sampled each rising edge.
REQ-009 b  in  1  consequent, sampled each rising edge.
REQ-010 pass  out  1  one-cycle pulse: consequent held at check edge.
REQ-011 fail  out  1  one-cycle pulse: consequent absent at check edge.
REQ-012 pass_cnt  out  CNT_W  saturating count of passes.
REQ-013 fail_cnt  out  CNT_W  saturating count of failures.
REQ-014 err_sticky  out  1  set on first failure, held until clr or reset.
REQ-015 first_fail_ts  out  TS_W  timestamp of the first failure since the last clr/reset.
REQ-016 pending  out  1  high while any accepted antecedent awaits its check.

Function
REQ-017 An antecedent is accepted at edge E0 when a=1 and en=1; its check occurs at edge E0+DELAY.
REQ-018 At the check edge, b=1 registers pass=1; b=0 registers fail=1; each pulse is high for exactly the following cycle.
REQ-019 Tracking is a DELAY-deep shift register, so overlapping antecedents (a high on consecutive edges) are each checked independently; no antecedent is dropped or merged.
REQ-020 With no antecedent maturing at an edge, pass=0 and fail=0 (no vacuous pass reported).
REQ-021 pass and fail are never high in the same cycle.
REQ-022 Deasserting en does not cancel in-flight antecedents; they are still checked and reported.
REQ-023 pass_cnt/fail_cnt increment at the same edge that registers pass/fail and hold at 2^CNT_W-1 (no wrap).
REQ-024 Timestamp counter increments every edge from 0 after reset and wraps modulo 2^TS_W.
REQ-025 On the first failure with err_sticky=0, first_fail_ts captures the timestamp value at the check edge; later failures leave it unchanged.
REQ-026 clr=1 at an edge zeroes pass_cnt, fail_cnt, err_sticky and first_fail_ts; clr wins over a same-edge increment or capture; the pass/fail pulse for that edge is still produced.
REQ-027 clr does not flush the shift register or reset the timestamp.
REQ-028 pending = OR of all shift-register stages.

Reset
REQ-029 rst_n=0 asynchronously clears the shift register, pass, fail, pass_cnt, fail_cnt, err_sticky, first_fail_ts, pending and timestamp to 0.
REQ-030 Reset mid-window discards all in-flight antecedents; no pass/fail is reported for them after release.
REQ-031 The first antecedent sample occurs at the first rising edge after rst_n deasserts.

Structure
REQ-032 Package latency_chk_pkg holds the DELAY/CNT_W/TS_W defaults and the legal DELAY bounds.
REQ-033 Sub-module sat_counter (parameter width; inputs clr, inc; output count) is instantiated once for pass_cnt and once for fail_cnt.
REQ-034 An elaboration-time check rejects DELAY outside 1..15.

Verification
REQ-035 DELAY=3, single a pulse at edge 1, b=1 at edge 4 -> pass high in cycle after edge 4; pass_cnt=1; fail_cnt=0.
REQ-036 DELAY=3, a pulse at edge 1, b=1 at edge 5 only -> fail after edge 4; err_sticky=1; first_fail_ts=4.
REQ-037 a high at edges 1,2,3; b high at edges 4,6 only -> pass, fail, pass on consecutive cycles; pass_cnt=2; fail_cnt=1.
REQ-038 CNT_W=2, 5 passing transactions -> pass_cnt saturates at 3; clr with a same-edge pass -> pass_cnt=0, pass pulse still seen.
REQ-039 a at edge 1, rst_n low at edge 2.5, released before edge 4 -> no pass/fail ever reported for that antecedent; all outputs 0.
REQ-040 en=0 after accepting a at edge 1, a held high thereafter -> exactly one check result at edge 4; pending falls after edge 4.

Source files
------------

// File: rtl/latency_chk_pkg.sv
// Shared defaults and legal bounds for the latency checker.
// No ports; imported by latency_checker.
package latency_chk_pkg;

  localparam int unsigned DELAY_DEF = 3;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned TS_W_DEF  = 16;

  localparam int unsigned DELAY_MIN = 1;
  localparam int unsigned DELAY_MAX = 15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count one event), count (holds at all-ones, never wraps).
module sat_counter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/latency_checker.sv
// Checks that consequent b is high exactly DELAY cycles after each accepted
// antecedent a, reporting pass/fail pulses, saturating counters, a sticky
// error flag and the timestamp of the first failure.
// Ports: clk, rst_n (async active-low), en (accept new antecedents),
//        clr (sync clear of counters/sticky/capture), a, b,
//        pass/fail (one-cycle result pulses), pass_cnt/fail_cnt,
//        err_sticky, first_fail_ts, pending (any antecedent in flight).
module latency_checker
  import latency_chk_pkg::*;
#(
  parameter int unsigned DELAY = DELAY_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             pending
);

  // Reject illegal window depths at elaboration.
  if ((DELAY < DELAY_MIN) || (DELAY > DELAY_MAX)) begin : g_bad_delay
    $fatal(1, "latency_checker: DELAY must be within 1..15");
  end

  logic [DELAY-1:0] track;
  logic [DELAY-1:0] track_next;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  ts_next;
  logic             accept_c;
  logic             mature_c;
  logic             pass_c;
  logic             fail_c;

  // Bit k of track marks an antecedent accepted k+1 edges ago; the top bit
  // matures at the current edge. Shift form works for DELAY=1 as well.
  always_comb begin
    accept_c   = a & en;
    mature_c   = track[DELAY-1];
    pass_c     = mature_c & b;
    fail_c     = mature_c & ~b;
    track_next = (track << 1) | DELAY'(accept_c);
    // ts_next is the timestamp value that counts the current edge.
    ts_next    = ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track   <= '0;
      pending <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      ts      <= '0;
    end else begin
      track   <= track_next;
      pending <= |track_next;
      pass    <= pass_c;
      fail    <= fail_c;
      ts      <= ts_next;
    end
  end

  // First-failure capture; clear wins over a same-edge capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky    <= 1'b0;
      first_fail_ts <= '0;
    end else if (clr) begin
      err_sticky    <= 1'b0;
      first_fail_ts <= '0;
    end else if (fail_c && !err_sticky) begin
      err_sticky    <= 1'b1;
      first_fail_ts <= ts_next;
    end
  end

  sat_counter #(.width(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pass_c),
    .count (pass_cnt)
  );

  sat_counter #(.width(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (fail_c),
    .count (fail_cnt)
  );

endmodule

// File: tb/tb_latency_checker.sv
// Self-checking bench for latency_checker: directed scenarios plus random
// traffic compared against a queue-of-due-edges reference model.
module tb_latency_checker;

  localparam int unsigned DLY = 3;
  localparam int unsigned CW  = 2;
  localparam int unsigned TW  = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          pass;
  logic          fail;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          err_sticky;
  logic [TW-1:0] first_fail_ts;
  logic          pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int edge_no;
  int due[$];
  int m_pass, m_fail, m_pcnt, m_fcnt, m_sticky, m_ts, m_pending;

  latency_checker #(.DELAY(DLY), .CNT_W(CW), .TS_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .clr           (clr),
    .a             (a),
    .b             (b),
    .pass          (pass),
    .fail          (fail),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .err_sticky    (err_sticky),
    .first_fail_ts (first_fail_ts),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    edge_no = 0;
    due.delete();
    m_pass = 0; m_fail = 0; m_pcnt = 0; m_fcnt = 0;
    m_sticky = 0; m_ts = 0; m_pending = 0;
  endfunction

  // One rising edge as the rules describe it, edges numbered from 1 after reset.
  function automatic void model_edge(input bit ai, input bit bi, input bit eni, input bit clri);
    bit mat;
    edge_no++;
    mat = (due.size() > 0) && (due[0] == edge_no);
    if (mat) void'(due.pop_front());
    if (ai && eni) due.push_back(edge_no + DLY);
    m_pass = (mat && bi) ? 1 : 0;
    m_fail = (mat && !bi) ? 1 : 0;
    if (clri) begin
      m_pcnt = 0; m_fcnt = 0; m_sticky = 0; m_ts = 0;
    end else begin
      if (m_pass == 1 && m_pcnt < CNT_MAX) m_pcnt++;
      if (m_fail == 1 && m_fcnt < CNT_MAX) m_fcnt++;
      if (m_fail == 1 && m_sticky == 0) begin
        m_sticky = 1;
        m_ts = edge_no % (1 << TW);
      end
    end
    m_pending = (due.size() != 0) ? 1 : 0;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".pass"},    int'(pass), m_pass);
    chk({tag, ".fail"},    int'(fail), m_fail);
    chk({tag, ".excl"},    int'(pass & fail), 0);
    chk({tag, ".pcnt"},    int'(pass_cnt), m_pcnt);
    chk({tag, ".fcnt"},    int'(fail_cnt), m_fcnt);
    chk({tag, ".sticky"},  int'(err_sticky), m_sticky);
    chk({tag, ".ts"},      int'(first_fail_ts), m_ts);
    chk({tag, ".pending"}, int'(pending), m_pending);
  endtask

  task automatic step(input string tag, input bit ai, input bit bi, input bit eni, input bit clri);
    a = ai; b = bi; en = eni; clr = clri;
    @(posedge clk);
    model_edge(ai, bi, eni, clri);
    #1;
    compare_all(tag);
  endtask

  // Full reset sequence; leaves time just after a falling edge.
  task automatic do_reset(input string tag);
    a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all({tag, ".in_rst"});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single passing transaction.
    do_reset("r035");
    step("r035.e1", 1, 0, 1, 0);
    step("r035.e2", 0, 0, 1, 0);
    step("r035.e3", 0, 0, 1, 0);
    step("r035.e4", 0, 1, 1, 0);
    chk("r035.pass_pulse", int'(pass), 1);
    chk("r035.pass_cnt", int'(pass_cnt), 1);
    chk("r035.fail_cnt", int'(fail_cnt), 0);
    step("r035.e5", 0, 0, 1, 0);
    chk("r035.no_vacuous", int'(pass | fail), 0);

    // Late consequent is a failure.
    do_reset("r036");
    step("r036.e1", 1, 0, 1, 0);
    step("r036.e2", 0, 0, 1, 0);
    step("r036.e3", 0, 0, 1, 0);
    step("r036.e4", 0, 0, 1, 0);
    chk("r036.fail_pulse", int'(fail), 1);
    chk("r036.sticky", int'(err_sticky), 1);
    chk("r036.first_ts", int'(first_fail_ts), 4);
    step("r036.e5", 0, 1, 1, 0);
    chk("r036.late_b_ignored", int'(pass | fail), 0);

    // Overlapping antecedents checked independently.
    do_reset("r037");
    step("r037.e1", 1, 0, 1, 0);
    step("r037.e2", 1, 0, 1, 0);
    step("r037.e3", 1, 0, 1, 0);
    step("r037.e4", 0, 1, 1, 0);
    chk("r037.p1", int'(pass), 1);
    step("r037.e5", 0, 0, 1, 0);
    chk("r037.f1", int'(fail), 1);
    chk("r037.ts", int'(first_fail_ts), 5);
    step("r037.e6", 0, 1, 1, 0);
    chk("r037.p2", int'(pass), 1);
    chk("r037.pass_cnt", int'(pass_cnt), 2);
    chk("r037.fail_cnt", int'(fail_cnt), 1);

    // Saturation, then clear on the same edge as a pass.
    do_reset("r038");
    for (int i = 0; i < 5; i++) step("r038.fill", 1, 1, 1, 0);
    for (int i = 0; i < DLY; i++) step("r038.drain", 0, 1, 1, 0);
    chk("r038.sat", int'(pass_cnt), 3);
    step("r038.a", 1, 0, 1, 0);
    step("r038.w1", 0, 0, 1, 0);
    step("r038.w2", 0, 0, 1, 0);
    step("r038.clr_edge", 0, 1, 1, 1);
    chk("r038.pulse_kept", int'(pass), 1);
    chk("r038.cleared", int'(pass_cnt), 0);

    // Reset in the middle of a window discards the antecedent.
    do_reset("r039");
    step("r039.e1", 1, 0, 1, 0);
    step("r039.e2", 0, 0, 1, 0);
    #4;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("r039.async");
    chk("r039.pending_dropped", int'(pending), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("r039.after", 0, i[0], 1, 0);
      chk("r039.silent", int'(pass | fail), 0);
    end

    // en low does not cancel an in-flight antecedent.
    do_reset("r040");
    step("r040.e1", 1, 0, 1, 0);
    step("r040.e2", 1, 0, 0, 0);
    chk("r040.pending", int'(pending), 1);
    step("r040.e3", 1, 0, 0, 0);
    step("r040.e4", 1, 1, 0, 0);
    chk("r040.result", int'(pass), 1);
    chk("r040.pending_fell", int'(pending), 0);
    step("r040.e5", 1, 1, 0, 0);
    chk("r040.one_result", int'(pass | fail), 0);
    step("r040.e6", 1, 0, 0, 0);

    // Random traffic; the long reset-free stretch covers timestamp wrap.
    do_reset("rnd");
    for (int i = 0; i < 1200; i++) begin
      bit ra, rb, ren, rclr;
      if (i > 600 && $urandom_range(0, 149) == 0) do_reset("rnd.rst");
      ra   = ($urandom_range(0, 2) != 0);
      rb   = $urandom_range(0, 1) != 0;
      ren  = ($urandom_range(0, 7) != 0);
      rclr = ($urandom_range(0, 59) == 0);
      step("rnd", ra, rb, ren, rclr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
